// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the DMEM two-port arbiter.
//   PORT_CORE / PORT_DBG : requester bit positions in the req/we/lock/gnt vectors
//   DEPTH_DEFAULT        : DMEM size in words; addresses >= DEPTH are out of range
//   LOCK_MAX_DEFAULT     : idle cycles a lock owner may hold without a grant
//   owner_e              : lock owner encoding (none / core / debug)
//   owner_of()           : maps a one-hot grant to the matching owner code
package dmem_pkg;

   localparam bit PORT_CORE = 1'b0;
   localparam bit PORT_DBG  = 1'b1;

   localparam int unsigned DEPTH_DEFAULT    = 1024;
   localparam int unsigned LOCK_MAX_DEFAULT = 16;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CORE = 2'd1,
      OWNER_DBG  = 2'd2
   } owner_e;

   function automatic owner_e owner_of(input logic [1:0] gnt);
      if (gnt[PORT_DBG]) begin
         return OWNER_DBG;
      end
      if (gnt[PORT_CORE]) begin
         return OWNER_CORE;
      end
      return OWNER_NONE;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side bus of the DMEM arbiter.
//   req[1:0]     per-port request (bit0 core, bit1 debug/DMA)
//   we[1:0]      per-port write enable
//   lock[1:0]    per-port: keep ownership after this access
//   addr0/addr1  word address per port
//   wd0/wd1      write data per port
//   gnt[1:0]     one-hot grant (combinational)
//   rvalid[1:0]  read data valid (registered)
//   err[1:0]     out-of-range response (registered)
//   rdata        shared registered read data
// master: requesters; slave: the arbiter.
interface dmem_arbiter_if;

   logic [1:0]  req;
   logic [1:0]  we;
   logic [1:0]  lock;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wd0;
   logic [31:0] wd1;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [1:0]  err;
   logic [31:0] rdata;

   modport master (
      output req, we, lock, addr0, addr1, wd0, wd1,
      input  gnt, rvalid, err, rdata
   );

   modport slave (
      input  req, we, lock, addr0, addr1, wd0, wd1,
      output gnt, rvalid, err, rdata
   );

endinterface

// File: rtl/dmem_lock_ctrl.sv
// dmem_lock_ctrl: lock ownership for atomic read-modify-write sequences.
//   clk, rst    clock, asynchronous active-high reset
//   gnt[1:0]    one-hot grant of the current cycle (a grant is a completed access)
//   lock[1:0]   per-port lock request accompanying the access
//   owner       current lock owner (registered)
//   lock_abort  one-cycle pulse when an idle owner is forcibly released
// The timer counts cycles an owner holds the lock without being granted;
// LOCK_MAX such cycles release the lock.
module dmem_lock_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] gnt,
   input  logic [1:0] lock,
   output owner_e     owner,
   output logic       lock_abort
);

   // Timer only ever holds 0..LOCK_MAX-1; reaching LOCK_MAX is acted on at the edge.
   localparam int unsigned TIMER_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   owner_e               owner_q, owner_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 abort_q, abort_d;
   owner_e               granted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWNER_NONE;
         timer_q <= '0;
         abort_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         timer_q <= timer_d;
         abort_q <= abort_d;
      end
   end

   // A grant takes priority over the timeout: while an owner exists only the
   // owner can be granted, so any grant both refreshes the timer and blocks the abort.
   always_comb begin
      granted = owner_of(gnt);
      owner_d = owner_q;
      timer_d = timer_q;
      abort_d = 1'b0;
      if (granted != OWNER_NONE) begin
         timer_d = '0;
         if (|(gnt & lock)) begin
            owner_d = granted;
         end else if (owner_q == granted) begin
            owner_d = OWNER_NONE;
         end
      end else if (owner_q != OWNER_NONE) begin
         if (timer_q == TIMER_W'(LOCK_MAX - 1)) begin
            owner_d = OWNER_NONE;
            timer_d = '0;
            abort_d = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   always_comb begin
      owner      = owner_q;
      lock_abort = abort_q;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of the pipelined DMEM.
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     requester bus: req/we/lock/addr0/addr1/wd0/wd1 in,
//                   gnt (comb), rvalid/err/rdata (registered) out
//   lock_abort      one-cycle pulse when a lock times out
//   mem_we/mem_addr/mem_wd  drive to DMEM, all zero when nothing is granted
//   mem_rd          combinational DMEM read data
// Optional build macro DMEM_ARB_STALL_CNT_EN adds stall_cnt0/stall_cnt1:
// saturating counts of cycles each port requested without being granted.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEFAULT,
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   dmem_arbiter_if.slave bus,
   output logic         lock_abort,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wd,
   input  logic [31:0]  mem_rd
`ifdef DMEM_ARB_STALL_CNT_EN
   ,
   output logic [31:0]  stall_cnt0,
   output logic [31:0]  stall_cnt1
`endif
);

   owner_e      owner;
   logic [1:0]  gnt;
   logic        rr_ptr_q, rr_ptr_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        any_gnt;
   logic        sel_we;
   logic        sel_lock;
   logic        sel_in_range;
   logic [31:0] sel_addr;
   logic [31:0] sel_wd;

   dmem_lock_ctrl #(
      .LOCK_MAX (LOCK_MAX)
   ) u_lock_ctrl (
      .clk        (clk),
      .rst        (rst),
      .gnt        (gnt),
      .lock       (bus.lock),
      .owner      (owner),
      .lock_abort (lock_abort)
   );

   // rr_ptr indexes the favoured port directly (0 = core, 1 = debug).
   always_comb begin
      gnt = '0;
      unique case (owner)
         OWNER_CORE: gnt[PORT_CORE] = bus.req[PORT_CORE];
         OWNER_DBG:  gnt[PORT_DBG]  = bus.req[PORT_DBG];
         default: begin
            if (&bus.req) begin
               gnt[rr_ptr_q] = 1'b1;
            end else begin
               gnt = bus.req;
            end
         end
      endcase
   end

   always_comb begin
      any_gnt  = |gnt;
      sel_addr = '0;
      sel_wd   = '0;
      sel_we   = 1'b0;
      sel_lock = 1'b0;
      if (gnt[PORT_DBG]) begin
         sel_addr = bus.addr1;
         sel_wd   = bus.wd1;
         sel_we   = bus.we[PORT_DBG];
         sel_lock = bus.lock[PORT_DBG];
      end else if (gnt[PORT_CORE]) begin
         sel_addr = bus.addr0;
         sel_wd   = bus.wd0;
         sel_we   = bus.we[PORT_CORE];
         sel_lock = bus.lock[PORT_CORE];
      end
      sel_in_range = (sel_addr < 32'(DEPTH));
      mem_we       = sel_we & sel_in_range;
      mem_addr     = sel_addr;
      mem_wd       = sel_wd;
   end

   // Only accesses outside a lock sequence move the round-robin pointer;
   // after a core access the debug port is favoured and vice versa.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_gnt && (owner == OWNER_NONE) && !sel_lock) begin
         rr_ptr_d = gnt[PORT_CORE];
      end
   end

   always_comb begin
      rvalid_d = '0;
      err_d    = '0;
      rdata_d  = rdata_q;
      if (any_gnt) begin
         if (!sel_in_range) begin
            err_d = gnt;
         end else if (!sel_we) begin
            rvalid_d = gnt;
            rdata_d  = mem_rd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
         rvalid_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;

`ifdef DMEM_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt0_q, stall_cnt0_d;
   logic [31:0] stall_cnt1_q, stall_cnt1_d;

   always_comb begin
      stall_cnt0_d = stall_cnt0_q;
      stall_cnt1_d = stall_cnt1_q;
      if (bus.req[PORT_CORE] && !gnt[PORT_CORE] && (stall_cnt0_q != '1)) begin
         stall_cnt0_d = stall_cnt0_q + 1'b1;
      end
      if (bus.req[PORT_DBG] && !gnt[PORT_DBG] && (stall_cnt1_q != '1)) begin
         stall_cnt1_d = stall_cnt1_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt0_q <= '0;
         stall_cnt1_q <= '0;
      end else begin
         stall_cnt0_q <= stall_cnt0_d;
         stall_cnt1_q <= stall_cnt1_d;
      end
   end

   assign stall_cnt0 = stall_cnt0_q;
   assign stall_cnt1 = stall_cnt1_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the pipelined data memory: port 0 = core load/store stage, port 1 = debug/DMA master.
- Round-robin grant, one access per cycle, registered read response.
- Lock for atomic read-modify-write sequences, with timeout.
- Drives the single DMEM_Pipe port (we/addr/wd, combinational rd).

Parameters:
- DEPTH, 1024, DMEM words; addr >= DEPTH is out of range.
- LOCK_MAX, 16, max cycles a lock may be held without a granted access by its owner.

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-port request (bit0 core, bit1 dbg)
- we  in  2  per-port write enable
- lock  in  2  per-port: hold ownership after this access
- addr0, addr1  in  32  word address per port
- wd0, wd1  in  32  write data per port
- gnt  out  2  one-hot grant, combinational
- rvalid  out  2  read data valid, registered
- err  out  2  out-of-range response, registered
- rdata  out  32  registered read data, shared
- lock_abort  out  1  one-cycle pulse on lock timeout
- mem_we  out  1  to DMEM WE
- mem_addr  out  32  to DMEM addr
- mem_wd  out  32  to DMEM WD
- mem_rd  in  32  from DMEM RD

Behaviour:
- Handshake: an access completes in any cycle with req[i] && gnt[i]. The requester holds we/addr/wd stable while req=1 && gnt=0. A new access may follow back-to-back.
- Grant (combinational):
  - If a lock owner exists, only the owner may be granted.
  - Otherwise, a single requester wins.
  - If both request, the port indicated by rr_ptr wins.
  - gnt is at most one-hot; gnt=0 when req=0.
- rr_ptr: after each completed unlocked access by port i, rr_ptr <= ~i (the other port is favoured next).
- Memory drive:
  - mem_addr/mem_wd follow the granted port, else 0.
  - mem_we = granted we AND in range.
  - Out-of-range writes never reach memory.
- Response: one cycle after a granted access:
  - Read in range: rvalid[i]=1, rdata = mem_rd sampled at the grant cycle.
  - Any access out of range: err[i]=1, rvalid[i]=0, rdata held.
  - In-range write: no response pulse.
- rdata holds its value between responses.
- Lock:
  - A granted access with lock[i]=1 sets owner=i (or keeps it).
  - A granted access by the owner with lock=0 clears the owner after the cycle.
  - Lock timer: reset to 0 on every owner grant, otherwise increments while an owner exists.
  - When the timer reaches LOCK_MAX: owner cleared, lock_abort pulses 1 cycle, timer cleared.
- Simultaneous events:
  - An owner grant in the same cycle as the timeout: the grant wins, no abort.
  - A lock request by a non-owner is impossible because it is not granted.
- Reset values: rr_ptr=0 (core favoured), owner=none, timer=0, rvalid=0, err=0, rdata=0, lock_abort=0.
  - gnt/mem_* are combinational from state and inputs; all-zero when req=0.
- Reset mid-operation: an in-flight response is dropped and the lock is released. Any write already committed at a prior edge stays in memory.

Optional Feature:
- Macro: DMEM_ARB_STALL_CNT_EN.
- With it defined: extra outputs stall_cnt0 and stall_cnt1, 32 bits each.
  - Each increments every cycle req[i] && !gnt[i], saturating at all-ones.
  - Both reset to 0.
- Without it: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg: port index constants PORT_CORE=0 and PORT_DBG=1, DEPTH default, owner encoding (NONE/CORE/DBG).
- Sub-module: dmem_lock_ctrl (owner register, timer, lock_abort).
- Grant, rr_ptr and response logic live in the top.

Test Plan:
- Single core read: DMEM[5]=0xDEAD0005; req=01, we=0, addr0=5 → gnt=01 same cycle; next cycle rvalid=01, rdata=0xDEAD0005.
- Contention fairness: req=11 held for 4 cycles from reset → gnt sequence 01,10,01,10.
- Write then read, dbg port: write addr1=7, wd1=0x12345678, then read 7 back-to-back → rdata=0x12345678 on the cycle after the read grant.
- Out-of-range: core write addr0=1024 → mem_we=0, err=01 next cycle, memory unchanged.
- Lock and timeout: dbg locked read at addr 3, then idle with core req=1 → core gnt=0 for 16 cycles, lock_abort pulses, core granted the next cycle.
- Async reset: assert rst mid-lock with response pending → rvalid=0, owner cleared immediately; after release, core favoured first.
